// File: rtl/pcileech_tlps128_src_demux.sv
// RX-side TLP demux: routes each whole 128-bit TLP to one of four sinks (Cpl, Cfg, BAR, other)
// chosen from the first-beat header, through a single registered output stage.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no packet open; next accepted beat must carry tuser[0]
// FWD     | packet open, beats routed to the sink locked in sel_q
// DROP    | packet open, classified "other" and being discarded
module pcileech_tlps128_src_demux #(
  parameter bit DROP_OTHER = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic               clk_pcie,
  input  logic               rst,
  input  logic               en,
  input  logic [127:0]       in_tdata,
  input  logic [3:0]         in_tkeepdw,
  input  logic [8:0]         in_tuser,
  input  logic               in_tlast,
  input  logic               in_tvalid,
  output logic               in_tready,
  output logic [127:0]       out_tdata,
  output logic [3:0]         out_tkeepdw,
  output logic [8:0]         out_tuser,
  output logic               out_tlast,
  output logic [3:0]         out_tvalid,
  input  logic [3:0]         out_tready,
  output logic [4*CNT_W-1:0] pkt_cnt,
  output logic [7:0]         err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [1:0] SINK_CPL   = 2'd0;
  localparam logic [1:0] SINK_CFG   = 2'd1;
  localparam logic [1:0] SINK_BAR   = 2'd2;
  localparam logic [1:0] SINK_OTHER = 2'd3;

  state_t                  state_q, state_d;
  logic [1:0]              sel_q, sel_d;

  logic [127:0]            out_tdata_q;
  logic [3:0]              out_tkeepdw_q;
  logic [8:0]              out_tuser_q;
  logic                    out_tlast_q;
  logic [3:0]              out_tvalid_q;
  logic [3:0][CNT_W-1:0]   cnt_q;
  logic [7:0]              err_q;

  logic [6:0]              hdr;
  logic [1:0]              cls;
  logic                    cls_fwd;
  logic                    first_beat;
  logic                    out_fire;
  logic                    slot_free;
  logic                    ready;
  logic                    accept;
  logic                    fwd;
  logic [1:0]              fwd_sel;
  logic                    err;

  assign hdr        = in_tdata[31:25];
  assign first_beat = in_tuser[0];

  // Header class; only meaningful on a first beat.
  always_comb begin
    cls = SINK_OTHER;
    if (hdr == 7'b0000101 || hdr == 7'b0100101) begin
      cls = SINK_CPL;
    end else if (hdr == 7'b0000010 || hdr == 7'b0100010) begin
      cls = SINK_CFG;
    end else if (in_tdata[28:24] == 5'b00000) begin
      cls = SINK_BAR;
    end
  end

  assign cls_fwd   = !(DROP_OTHER && (cls == SINK_OTHER));
  assign out_fire  = |(out_tvalid_q & out_tready);
  assign slot_free = !(|out_tvalid_q) || out_fire;
  assign accept    = in_tvalid && ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ready   = 1'b0;
    fwd     = 1'b0;
    fwd_sel = sel_q;
    err     = 1'b0;

    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          // Orphan beats are swallowed without needing the output slot.
          if (in_tvalid && !first_beat) ready = 1'b1;
          else                          ready = slot_free && en;
        end
        ST_FWD:  ready = slot_free;
        ST_DROP: begin
          // A restarting first beat that must be forwarded still needs the slot.
          if (in_tvalid && first_beat && cls_fwd) ready = slot_free;
          else                                    ready = 1'b1;
        end
        default: ready = 1'b0;
      endcase

      if (accept) begin
        if (first_beat) begin
          err     = (state_q != ST_IDLE);
          fwd     = cls_fwd;
          fwd_sel = cls;
          sel_d   = cls;
          if (in_tlast)     state_d = ST_IDLE;
          else if (cls_fwd) state_d = ST_FWD;
          else              state_d = ST_DROP;
        end else if (state_q == ST_IDLE) begin
          err = 1'b1;
        end else begin
          fwd = (state_q == ST_FWD);
          if (in_tlast) state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SINK_CPL;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      out_tdata_q   <= '0;
      out_tkeepdw_q <= '0;
      out_tuser_q   <= '0;
      out_tlast_q   <= 1'b0;
      out_tvalid_q  <= '0;
    end else if (fwd) begin
      out_tdata_q   <= in_tdata;
      out_tkeepdw_q <= in_tkeepdw;
      out_tuser_q   <= in_tuser;
      out_tlast_q   <= in_tlast;
      out_tvalid_q  <= 4'b0001 << fwd_sel;
    end else if (out_fire) begin
      out_tvalid_q  <= '0;
    end
  end

  // Packets are counted as their tlast beat leaves the output register.
  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (out_tvalid_q[i] && out_tready[i] && out_tlast_q) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
      if (err && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign in_tready   = ready;
  assign out_tdata   = out_tdata_q;
  assign out_tkeepdw = out_tkeepdw_q;
  assign out_tuser   = out_tuser_q;
  assign out_tlast   = out_tlast_q;
  assign out_tvalid  = out_tvalid_q;
  assign pkt_cnt     = cnt_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_pcileech_tlps128_src_demux.sv
// Bench for pcileech_tlps128_src_demux: scoreboard of expected output beats plus per-scenario
// checks, run against one instance forwarding "other" packets and one dropping them.
module tb_pcileech_tlps128_src_demux;

  localparam int CNT_W = 16;

  logic               clk_pcie = 1'b0;
  logic               rst      = 1'b1;
  logic               en       = 1'b0;
  logic [127:0]       in_tdata = '0;
  logic [3:0]         in_tkeepdw = '0;
  logic [8:0]         in_tuser = '0;
  logic               in_tlast = 1'b0;
  logic               in_tvalid = 1'b0;
  logic [3:0]         out_tready = 4'hF;

  logic               in_tready;
  logic [127:0]       out_tdata;
  logic [3:0]         out_tkeepdw;
  logic [8:0]         out_tuser;
  logic               out_tlast;
  logic [3:0]         out_tvalid;
  logic [4*CNT_W-1:0] pkt_cnt;
  logic [7:0]         err_cnt;

  logic               dr_in_tready;
  logic [127:0]       dr_out_tdata;
  logic [3:0]         dr_out_tkeepdw;
  logic [8:0]         dr_out_tuser;
  logic               dr_out_tlast;
  logic [3:0]         dr_out_tvalid;
  logic [4*CNT_W-1:0] dr_pkt_cnt;
  logic [7:0]         dr_err_cnt;

  pcileech_tlps128_src_demux #(.DROP_OTHER(1'b0), .CNT_W(CNT_W)) u_dut (
    .clk_pcie(clk_pcie), .rst(rst), .en(en),
    .in_tdata(in_tdata), .in_tkeepdw(in_tkeepdw), .in_tuser(in_tuser),
    .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeepdw(out_tkeepdw), .out_tuser(out_tuser),
    .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  pcileech_tlps128_src_demux #(.DROP_OTHER(1'b1), .CNT_W(CNT_W)) u_drop (
    .clk_pcie(clk_pcie), .rst(rst), .en(en),
    .in_tdata(in_tdata), .in_tkeepdw(in_tkeepdw), .in_tuser(in_tuser),
    .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(dr_in_tready),
    .out_tdata(dr_out_tdata), .out_tkeepdw(dr_out_tkeepdw), .out_tuser(dr_out_tuser),
    .out_tlast(dr_out_tlast), .out_tvalid(dr_out_tvalid), .out_tready(out_tready),
    .pkt_cnt(dr_pkt_cnt), .err_cnt(dr_err_cnt)
  );

  always #5 clk_pcie = ~clk_pcie;

  typedef struct {
    int           sink;
    logic [127:0] d;
    logic [3:0]   k;
    logic [8:0]   u;
    logic         l;
  } beat_t;

  beat_t sb_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  function automatic logic [127:0] mk(input logic [31:0] hdr);
    return {$urandom(), $urandom(), $urandom(), hdr};
  endfunction

  // Scoreboard: every beat leaving the primary instance must match the oldest expectation.
  beat_t      e;
  logic [3:0] ev;
  always @(negedge clk_pcie) begin
    #1;
    if (!rst && ((out_tvalid & out_tready) != 4'b0000)) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: out_tvalid=%b data=%h with nothing expected", out_tvalid, out_tdata);
      end else begin
        e  = sb_q.pop_front();
        ev = 4'b0001 << e.sink[1:0];
        if (out_tvalid !== ev || out_tdata !== e.d || out_tkeepdw !== e.k ||
            out_tuser !== e.u || out_tlast !== e.l) begin
          $display("FAIL sb_beat: got vld=%b d=%h k=%h u=%h l=%b, want vld=%b d=%h k=%h u=%h l=%b",
                   out_tvalid, out_tdata, out_tkeepdw, out_tuser, out_tlast, ev, e.d, e.k, e.u, e.l);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // Drives one beat until accepted; sink < 0 means no output is expected for it.
  task automatic send_beat(input logic [127:0] d, input logic [3:0] k, input logic [8:0] u,
                           input logic l, input int sink);
    int    waited;
    beat_t b;
    waited     = 0;
    in_tdata   = d;
    in_tkeepdw = k;
    in_tuser   = u;
    in_tlast   = l;
    in_tvalid  = 1'b1;
    #1;
    while (in_tready !== 1'b1 && waited < 50) begin
      @(negedge clk_pcie);
      #1;
      waited++;
    end
    if (in_tready !== 1'b1) begin
      n_chk++;
      $display("FAIL accept_timeout: in_tready=%b after %0d cycles, want 1", in_tready, waited);
      in_tvalid = 1'b0;
      return;
    end
    if (sink >= 0) begin
      b.sink = sink; b.d = d; b.k = k; b.u = u; b.l = l;
      sb_q.push_back(b);
    end
    @(negedge clk_pcie);
    in_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_pcie);
    in_tvalid  = 1'b0;
    rst        = 1'b1;
    sb_q.delete();
    repeat (2) @(negedge clk_pcie);
    rst        = 1'b0;
    en         = 1'b1;
    out_tready = 4'hF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_pcie);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; out_tready = 4'hF;
    in_tdata = mk(32'h4A000004); in_tkeepdw = 4'hF; in_tuser = 9'h001; in_tlast = 1'b0;
    in_tvalid = 1'b1;
    repeat (2) @(negedge clk_pcie);
    #1;
    n_chk++;
    if (out_tvalid !== 4'b0000 || in_tready !== 1'b0 || out_tdata !== 128'd0 ||
        out_tlast !== 1'b0 || out_tuser !== 9'd0 || out_tkeepdw !== 4'd0)
      $display("FAIL reset_outputs: vld=%b rdy=%b d=%h l=%b, want all zero", out_tvalid, in_tready, out_tdata, out_tlast);
    else n_pass++;
    n_chk++;
    if (pkt_cnt !== '0 || err_cnt !== 8'd0)
      $display("FAIL reset_counters: pkt_cnt=%h err_cnt=%0d, want 0", pkt_cnt, err_cnt);
    else n_pass++;
    in_tvalid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_cpl();
    logic [127:0] d0;
    do_reset();
    d0 = mk(32'h4A000004);
    send_beat(d0, 4'hF, 9'h0A3, 1'b0, 0);
    #1;
    n_chk++;
    if (out_tvalid !== 4'b0001 || out_tdata !== d0)
      $display("FAIL cpl_latency: vld=%b d=%h, want 0001 d=%h", out_tvalid, out_tdata, d0);
    else n_pass++;
    send_beat(mk(32'h11111111), 4'hF, 9'h0A2, 1'b0, 0);
    send_beat(mk(32'h22222222), 4'h3, 9'h0A2, 1'b1, 0);
    idle(3);
    n_chk++;
    if (pkt_cnt !== {16'd0, 16'd0, 16'd0, 16'd1})
      $display("FAIL cpl_pkt_cnt: pkt_cnt=%h, want 0000000000000001", pkt_cnt);
    else n_pass++;
    n_chk++;
    if (sb_q.size() != 0) $display("FAIL cpl_drain: %0d beats pending, want 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_beat(mk(32'h04000001), 4'h7, 9'h001, 1'b1, 1);
    #1;
    n_chk++;
    if (out_tvalid !== 4'b0010) $display("FAIL b2b_cfg_vld: vld=%b, want 0010", out_tvalid);
    else n_pass++;
    send_beat(mk(32'h40000001), 4'hF, 9'h101, 1'b0, 2);
    #1;
    n_chk++;
    if (out_tvalid !== 4'b0100) $display("FAIL b2b_mwr_vld: vld=%b, want 0100", out_tvalid);
    else n_pass++;
    send_beat(mk(32'hCAFEF00D), 4'h1, 9'h100, 1'b1, 2);
    idle(3);
    n_chk++;
    if (pkt_cnt !== {16'd0, 16'd1, 16'd1, 16'd0})
      $display("FAIL b2b_pkt_cnt: pkt_cnt=%h, want 0000000100010000", pkt_cnt);
    else n_pass++;
    n_chk++;
    if (err_cnt !== 8'd0) $display("FAIL b2b_err: err_cnt=%0d, want 0", err_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [127:0] d0, d1;
    do_reset();
    out_tready = 4'b1011;
    d0 = mk(32'h00000001);
    d1 = mk(32'h5A5A5A5A);
    send_beat(d0, 4'hF, 9'h001, 1'b0, 2);
    in_tdata = d1; in_tkeepdw = 4'h3; in_tuser = 9'h000; in_tlast = 1'b1; in_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++;
      if (in_tready !== 1'b0 || out_tvalid !== 4'b0100 || out_tdata !== d0 || out_tlast !== 1'b0)
        $display("FAIL bp_hold[%0d]: rdy=%b vld=%b d=%h, want 0 0100 d=%h", i, in_tready, out_tvalid, out_tdata, d0);
      else n_pass++;
      @(negedge clk_pcie);
    end
    out_tready = 4'hF;
    send_beat(d1, 4'h3, 9'h000, 1'b1, 2);
    #1;
    n_chk++;
    if (out_tvalid !== 4'b0100 || out_tdata !== d1 || out_tlast !== 1'b1)
      $display("FAIL bp_resume: vld=%b d=%h l=%b, want 0100 d=%h l=1", out_tvalid, out_tdata, out_tlast, d1);
    else n_pass++;
    idle(3);
    n_chk++;
    if (pkt_cnt !== {16'd0, 16'd1, 16'd0, 16'd0} || sb_q.size() != 0)
      $display("FAIL bp_pkt_cnt: pkt_cnt=%h pending=%0d, want 0000000100000000 and 0", pkt_cnt, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_other();
    do_reset();
    send_beat(mk(32'h34000000), 4'hF, 9'h001, 1'b0, 3);
    #1;
    n_chk++;
    if (out_tvalid !== 4'b1000) $display("FAIL other_fwd_vld: vld=%b, want 1000", out_tvalid);
    else n_pass++;
    n_chk++;
    if (dr_out_tvalid !== 4'b0000 || dr_in_tready !== 1'b1)
      $display("FAIL other_drop_state: vld=%b rdy=%b, want 0000 1", dr_out_tvalid, dr_in_tready);
    else n_pass++;
    send_beat(mk(32'h77777777), 4'h1, 9'h000, 1'b1, 3);
    #1;
    n_chk++;
    if (dr_out_tvalid !== 4'b0000 || dr_out_tlast !== 1'b0)
      $display("FAIL other_drop_tail: vld=%b l=%b, want 0000 0", dr_out_tvalid, dr_out_tlast);
    else n_pass++;
    idle(3);
    n_chk++;
    if (pkt_cnt[3*CNT_W +: CNT_W] !== 16'd1 || dr_pkt_cnt !== '0 || dr_err_cnt !== 8'd0)
      $display("FAIL other_cnt: fwd cnt3=%0d drop pkt_cnt=%h drop err=%0d, want 1 0 0",
               pkt_cnt[3*CNT_W +: CNT_W], dr_pkt_cnt, dr_err_cnt);
    else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    send_beat(mk(32'hDEAD0000), 4'hF, 9'h000, 1'b1, -1);
    #1;
    n_chk++;
    if (err_cnt !== 8'd1 || out_tvalid !== 4'b0000)
      $display("FAIL err_orphan: err_cnt=%0d vld=%b, want 1 0000", err_cnt, out_tvalid);
    else n_pass++;
    send_beat(mk(32'h4A000004), 4'hF, 9'h001, 1'b0, 0);
    send_beat(mk(32'h40000001), 4'hF, 9'h001, 1'b0, 2);
    #1;
    n_chk++;
    if (err_cnt !== 8'd2 || out_tvalid !== 4'b0100)
      $display("FAIL err_reroute: err_cnt=%0d vld=%b, want 2 0100", err_cnt, out_tvalid);
    else n_pass++;
    send_beat(mk(32'h12345678), 4'hF, 9'h000, 1'b1, 2);
    idle(3);
    n_chk++;
    if (pkt_cnt !== {16'd0, 16'd1, 16'd0, 16'd0})
      $display("FAIL err_reroute_cnt: pkt_cnt=%h, want 0000000100000000", pkt_cnt);
    else n_pass++;
    for (int i = 0; i < 300; i++) send_beat(mk(32'hBAD00000), 4'hF, 9'h000, 1'b0, -1);
    #1;
    n_chk++;
    if (err_cnt !== 8'd255) $display("FAIL err_saturate: err_cnt=%0d, want 255", err_cnt);
    else n_pass++;
  endtask

  task automatic test_en();
    logic [127:0] dc;
    do_reset();
    send_beat(mk(32'h4A000004), 4'hF, 9'h001, 1'b0, 0);
    en = 1'b0;
    send_beat(mk(32'h01010101), 4'hF, 9'h000, 1'b0, 0);
    send_beat(mk(32'h02020202), 4'hF, 9'h000, 1'b1, 0);
    dc = mk(32'h04000001);
    in_tdata = dc; in_tkeepdw = 4'h7; in_tuser = 9'h001; in_tlast = 1'b1; in_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (in_tready !== 1'b0) $display("FAIL en_stall[%0d]: in_tready=%b, want 0", i, in_tready);
      else n_pass++;
      @(negedge clk_pcie);
    end
    en = 1'b1;
    send_beat(dc, 4'h7, 9'h001, 1'b1, 1);
    idle(3);
    n_chk++;
    if (pkt_cnt !== {16'd0, 16'd0, 16'd1, 16'd1} || sb_q.size() != 0)
      $display("FAIL en_cnt: pkt_cnt=%h pending=%0d, want 0000000000010001 and 0", pkt_cnt, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    send_beat(mk(32'h04000001), 4'hF, 9'h001, 1'b1, 1);
    send_beat(mk(32'hDEAD0001), 4'hF, 9'h000, 1'b0, -1);
    out_tready = 4'b1110;
    send_beat(mk(32'h4A000004), 4'hF, 9'h001, 1'b0, 0);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk_pcie);
    #1;
    n_chk++;
    if (out_tvalid !== 4'b0000 || pkt_cnt !== '0 || err_cnt !== 8'd0 || in_tready !== 1'b0)
      $display("FAIL rst_mid: vld=%b pkt_cnt=%h err=%0d rdy=%b, want 0000 0 0 0",
               out_tvalid, pkt_cnt, err_cnt, in_tready);
    else n_pass++;
    rst = 1'b0;
    out_tready = 4'hF;
    send_beat(mk(32'h4A000004), 4'hF, 9'h001, 1'b0, 0);
    send_beat(mk(32'h0000AAAA), 4'hF, 9'h000, 1'b0, 0);
    send_beat(mk(32'h0000BBBB), 4'h1, 9'h000, 1'b1, 0);
    idle(3);
    n_chk++;
    if (pkt_cnt !== {16'd0, 16'd0, 16'd0, 16'd1} || err_cnt !== 8'd0 || sb_q.size() != 0)
      $display("FAIL rst_recover: pkt_cnt=%h err=%0d pending=%0d, want 0000000000000001 0 0",
               pkt_cnt, err_cnt, sb_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cpl();
    test_back_to_back();
    test_backpressure();
    test_other();
    test_errors();
    test_en();
    test_rst_mid();
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
